// File: rtl/uart_peak_frame_rx_pkg.sv
// Shared constants and state encodings for the spectrum-peak UART receive path.
package uart_peak_frame_rx_pkg;

    localparam logic [7:0] FRAME_HDR        = 8'hA5;
    localparam logic [5:0] PAD_MASK         = 6'h3F;
    localparam int         DEF_CLKS_PER_BIT = 234;   // 27 MHz / 115200, truncated

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_BREAK
    } byte_state_t;

    typedef enum logic [1:0] {
        P_HUNT,
        P_HDR,
        P_HI
    } parse_state_t;

endpackage

// File: rtl/uart_peak_frame_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchroniser, mid-bit sampling, start-glitch reject, break handling.
module uart_rx_byte
    import uart_peak_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_27M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);
    localparam int            TW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    logic [1:0]    r_sync;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    byte_state_t   r_state, w_next;
    logic          w_rx, w_half, w_full;

    assign w_rx      = r_sync[1];
    assign w_half    = (r_tmr == HALF_M1);
    assign w_full    = (r_tmr == FULL_M1);
    assign byte_data = r_shift;

    always_ff @(posedge clk_27M) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= B_IDLE;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (r_state)
            B_IDLE:  if (!w_rx) w_next = B_START;
            B_START: if (w_half) w_next = w_rx ? B_IDLE : B_DATA;
            B_DATA:  if (w_full && r_bit == 3'd7) w_next = B_STOP;
            B_STOP: begin
                if (w_full) begin
                    if (w_rx) begin
                        byte_valid = 1'b1;
                        w_next     = B_IDLE;
                    end else begin
                        byte_err = 1'b1;
                        w_next   = B_BREAK;
                    end
                end
            end
            B_BREAK: if (w_rx) w_next = B_IDLE;
            default: w_next = B_IDLE;
        endcase
    end

    // Timer restarts on every state change and at each data-bit boundary.
    always_ff @(posedge clk_27M) begin
        if (rst) begin
            r_tmr   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_next != r_state || r_state == B_IDLE || r_state == B_BREAK ||
                (r_state == B_DATA && w_full))
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + 1'b1;

            if (r_state == B_START)
                r_bit <= '0;
            else if (r_state == B_DATA && w_full)
                r_bit <= r_bit + 1'b1;

            if (r_state == B_DATA && w_full)
                r_shift <= {w_rx, r_shift[7:1]};
        end
    end

endmodule

// File: rtl/uart_peak_frame_rx.sv
// Peak-frame receiver: parses {A5, idx[9:2], {idx[1:0],6'b0}} from the UART byte stream.
module uart_peak_frame_rx
    import uart_peak_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = 4 * 10 * CLKS_PER_BIT
) (
    input  logic        clk_27M,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [9:0]  peak_index,
    output logic        index_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam int             TOW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TOW-1:0] TMO_M1 = TOW'(TIMEOUT_CLKS - 1);

    logic [7:0]     w_byte;
    logic           w_bvalid, w_berr;
    parse_state_t   r_state, w_next;
    logic [7:0]     r_hi;
    logic [TOW-1:0] r_tmo;
    logic           w_good, w_bad, w_tmo;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk_27M    (clk_27M),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_data  (w_byte),
        .byte_valid (w_bvalid),
        .byte_err   (w_berr)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo = (r_state != P_HUNT) && (r_tmo == TMO_M1) && !w_bvalid && !w_berr;

    always_comb begin
        w_next = r_state;
        w_good = 1'b0;
        w_bad  = 1'b0;
        case (r_state)
            P_HUNT: if (w_bvalid && w_byte == FRAME_HDR) w_next = P_HDR;
            P_HDR: begin
                if (w_bvalid) begin
                    w_next = P_HI;
                end else if (w_berr || w_tmo) begin
                    w_bad  = 1'b1;
                    w_next = P_HUNT;
                end
            end
            P_HI: begin
                if (w_bvalid) begin
                    w_next = P_HUNT;
                    if ((w_byte[5:0] & PAD_MASK) == 6'd0) w_good = 1'b1;
                    else                                  w_bad  = 1'b1;
                end else if (w_berr || w_tmo) begin
                    w_bad  = 1'b1;
                    w_next = P_HUNT;
                end
            end
            default: w_next = P_HUNT;
        endcase
    end

    always_ff @(posedge clk_27M) begin
        if (rst) begin
            r_state     <= P_HUNT;
            r_hi        <= '0;
            r_tmo       <= '0;
            peak_index  <= '0;
            index_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            r_state     <= w_next;
            index_valid <= w_good;
            frame_err   <= w_bad;
            if (r_state == P_HDR && w_bvalid)
                r_hi <= w_byte;
            if (r_state == P_HUNT || w_bvalid || w_tmo)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;
            if (w_good) begin
                peak_index <= {r_hi, w_byte[7:6]};
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_peak_frame_rx.sv
// Bench for uart_peak_frame_rx: bit-accurate 8N1 line driver plus a frame-level reference model.
module tb_uart_peak_frame_rx;

    localparam int CPB = 16;
    localparam int TMO = 4 * 10 * CPB;

    logic        clk_27M = 1'b0;
    logic        rst     = 1'b1;
    logic        uart_rx = 1'b1;
    logic [9:0]  peak_index;
    logic        index_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    uart_peak_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk_27M     (clk_27M),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .peak_index  (peak_index),
        .index_valid (index_valid),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_27M = ~clk_27M;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, obs_iv = 0, obs_fe = 0, obs_both = 0, iv_cyc = 0, last_start = 0;

    always @(negedge clk_27M) begin
        cyc = cyc + 1;
        if (index_valid) begin obs_iv = obs_iv + 1; iv_cyc = cyc; end
        if (frame_err) obs_fe = obs_fe + 1;
        if (index_valid && frame_err) obs_both = obs_both + 1;
    end

    // Reference model: works on whole bytes and frames, not on line timing.
    logic [9:0]  exp_peak = '0;
    logic [15:0] exp_cnt  = '0;
    int          exp_iv = 0, exp_fe = 0;
    bit          in_frame = 0;
    logic [7:0]  fb[$];

    task automatic model_byte(input logic [7:0] b);
        if (!in_frame) begin
            if (b == 8'hA5) begin in_frame = 1; fb.delete(); end
        end else begin
            fb.push_back(b);
            if (fb.size() == 2) begin
                in_frame = 0;
                if (fb[1][5:0] == 6'd0) begin
                    exp_peak = {fb[0], fb[1][7:6]};
                    exp_cnt  = exp_cnt + 16'd1;
                    exp_iv++;
                end else exp_fe++;
            end
        end
    endtask

    task automatic model_abort();
        if (in_frame) begin exp_fe++; in_frame = 0; end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk_27M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic xmit(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk_27M);
        @(negedge clk_27M);
        n_chk++; if (peak_index !== 10'd0) $display("FAIL reset peak_index got %h want 0", peak_index); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd0) $display("FAIL reset frame_cnt got %h want 0", frame_cnt); else n_pass++;
        n_chk++; if ({index_valid, frame_err} !== 2'b00) $display("FAIL reset pulses got %b want 00", {index_valid, frame_err}); else n_pass++;
        @(posedge clk_27M); #1;
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_basic_frame();
        int iv0, fe0, lat;
        iv0 = obs_iv; fe0 = obs_fe;
        xmit(8'hA5); xmit(8'h2B); xmit(8'h80);
        lat = iv_cyc - last_start;
        n_chk++; if (peak_index !== 10'd174) $display("FAIL basic peak_index got %0d want 174", peak_index); else n_pass++;
        n_chk++; if (obs_iv - iv0 !== 1) $display("FAIL basic index_valid pulses got %0d want 1", obs_iv - iv0); else n_pass++;
        n_chk++; if (frame_cnt !== exp_cnt) $display("FAIL basic frame_cnt got %0d want %0d", frame_cnt, exp_cnt); else n_pass++;
        n_chk++; if (obs_fe !== fe0) $display("FAIL basic frame_err pulses got %0d want 0", obs_fe - fe0); else n_pass++;
        n_chk++; if (lat < 9 * CPB || lat > 10 * CPB) $display("FAIL basic latency got %0d want %0d..%0d", lat, 9 * CPB, 10 * CPB); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_hunt_hdr_data();
        xmit(8'h11); xmit(8'hA5); xmit(8'hA5); xmit(8'hC0);
        n_chk++; if (peak_index !== 10'h297) $display("FAIL hunt peak_index got %h want 297", peak_index); else n_pass++;
        n_chk++; if (obs_iv !== exp_iv) $display("FAIL hunt index_valid count got %0d want %0d", obs_iv, exp_iv); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_bad_pad();
        xmit(8'hA5); xmit(8'h40); xmit(8'h81);
        n_chk++; if (obs_fe !== exp_fe) $display("FAIL badpad frame_err count got %0d want %0d", obs_fe, exp_fe); else n_pass++;
        n_chk++; if (peak_index !== exp_peak) $display("FAIL badpad peak_index got %h want %h", peak_index, exp_peak); else n_pass++;
        n_chk++; if (frame_cnt !== exp_cnt) $display("FAIL badpad frame_cnt got %0d want %0d", frame_cnt, exp_cnt); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = obs_fe;
        xmit(8'hA5);
        uart_rx = 1'b1;
        repeat (TMO - 20) @(posedge clk_27M);
        #1;
        n_chk++; if (obs_fe !== fe0) $display("FAIL timeout early frame_err got %0d want %0d", obs_fe, fe0); else n_pass++;
        repeat (TMO + 40) @(posedge clk_27M);
        #1;
        model_abort();
        n_chk++; if (obs_fe !== exp_fe) $display("FAIL timeout frame_err count got %0d want %0d", obs_fe, exp_fe); else n_pass++;
        xmit(8'hA5); xmit(8'h00); xmit(8'h40);
        n_chk++; if (peak_index !== 10'd1) $display("FAIL timeout recover peak_index got %0d want 1", peak_index); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_stop_break();
        xmit(8'hA5); xmit(8'h12);
        send_byte(8'h55, 1'b0);
        model_abort();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        idle_bits(2);
        n_chk++; if (obs_fe !== exp_fe) $display("FAIL break frame_err count got %0d want %0d", obs_fe, exp_fe); else n_pass++;
        xmit(8'hA5); xmit(8'h00); xmit(8'h00);
        n_chk++; if (peak_index !== 10'd0) $display("FAIL break peak_index got %0d want 0", peak_index); else n_pass++;
        n_chk++; if (obs_iv !== exp_iv) $display("FAIL break index_valid count got %0d want %0d", obs_iv, exp_iv); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_glitch_and_reset();
        xmit(8'hA5);
        uart_rx = 1'b0;
        repeat (5) @(posedge clk_27M);
        #1;
        uart_rx = 1'b1;
        idle_bits(2);
        xmit(8'h00); xmit(8'h40);
        n_chk++; if (peak_index !== 10'd1) $display("FAIL glitch peak_index got %0d want 1", peak_index); else n_pass++;
        n_chk++; if (obs_fe !== exp_fe) $display("FAIL glitch frame_err count got %0d want %0d", obs_fe, exp_fe); else n_pass++;
        xmit(8'hA5); xmit(8'h2B);
        rst = 1'b1;
        repeat (3) @(posedge clk_27M);
        #1;
        rst = 1'b0;
        in_frame = 0; exp_peak = '0; exp_cnt = '0;
        n_chk++; if (peak_index !== 10'd0 || frame_cnt !== 16'd0) $display("FAIL midrst outputs got %h/%h want 0/0", peak_index, frame_cnt); else n_pass++;
        idle_bits(2);
        xmit(8'hA5); xmit(8'h3C); xmit(8'hC0);
        n_chk++; if (peak_index !== 10'h0F3) $display("FAIL midrst peak_index got %h want 0f3", peak_index); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd1) $display("FAIL midrst frame_cnt got %0d want 1", frame_cnt); else n_pass++;
        idle_bits(2);
    endtask

    task automatic test_random();
        logic [7:0] hi, lo;
        for (int it = 0; it < 16; it++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1: begin xmit(8'hA5); xmit(hi); xmit({lo[7:6], 6'd0}); end
                2:    begin xmit(8'hA5); xmit(hi); xmit({lo[7:6], (lo[5:0] == 6'd0) ? 6'd1 : lo[5:0]}); end
                default: xmit(lo);
            endcase
            n_chk++; if (peak_index !== exp_peak) $display("FAIL random[%0d] peak_index got %h want %h", it, peak_index, exp_peak); else n_pass++;
        end
        idle_bits(2);
        n_chk++; if (frame_cnt !== exp_cnt) $display("FAIL random frame_cnt got %0d want %0d", frame_cnt, exp_cnt); else n_pass++;
        n_chk++; if (obs_iv !== exp_iv || obs_fe !== exp_fe) $display("FAIL random pulses got %0d/%0d want %0d/%0d", obs_iv, obs_fe, exp_iv, exp_fe); else n_pass++;
        n_chk++; if (obs_both !== 0) $display("FAIL overlap index_valid&frame_err got %0d want 0", obs_both); else n_pass++;
    endtask

    initial begin
        @(posedge clk_27M); #1;
        test_reset();
        test_basic_frame();
        test_hunt_hdr_data();
        test_bad_pad();
        test_timeout();
        test_stop_break();
        test_glitch_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
